// File: rtl/multiword_add_seq_if.sv
// Bundle of the upstream, downstream and adder-slice signals around multiword_add_seq.
// The sequencer takes the slave view; the surrounding logic takes the master view.
interface multiword_add_seq_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned N = WIDTH * WORDS;

  // Upstream operand handshake
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic             op_cin;
  logic             op_sub;

  // External combinational adder slice
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_c;

  // Downstream result handshake
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, op_a, op_b, op_cin, op_sub,
    input  add_s, add_c,
    input  out_ready,
    output in_ready,
    output add_a, add_b, add_cin,
    output out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, op_a, op_b, op_cin, op_sub,
    output add_s, add_c,
    output out_ready,
    input  in_ready,
    input  add_a, add_b, add_cin,
    input  out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Wide add/subtract built by stepping one external WIDTH-bit adder slice over WORDS
// cycles, with the carry chained through a register and valid/ready on both sides.
module multiword_add_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WORDS = 4
) (
  input logic                clk,
  input logic                rst_n,
  multiword_add_seq_if.slave bus
);

  localparam int unsigned N    = WIDTH * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic accept;
  logic last;

  assign accept = (state_q == StIdle) && bus.in_valid;
  assign last   = (idx_q == LastIdx);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid)  state_d = StRun;
      StRun:   if (last)          state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  // FSM outputs; the slice inputs are parked at zero whenever no slice is in flight
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    if (state_q == StRun) begin
      bus.add_a   = a_q[idx_q*WIDTH +: WIDTH];
      bus.add_b   = b_q[idx_q*WIDTH +: WIDTH];
      bus.add_cin = carry_q;
    end
  end

  // Datapath next state. Subtraction is a + ~b + 1, so b is inverted on capture and
  // the carry register is seeded with 1; op_cin only matters for addition.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    if (accept) begin
      a_d     = bus.op_a;
      b_d     = bus.op_sub ? ~bus.op_b : bus.op_b;
      carry_d = bus.op_sub ? 1'b1 : bus.op_cin;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      sum_d[idx_q*WIDTH +: WIDTH] = bus.add_s;
      carry_d = bus.add_c;
      idx_d   = idx_q + IdxW'(1);
      if (last) begin
        // Overflow from the operand sign bits (effective b) and the top result bit
        cout_d = bus.add_c;
        ovf_d  = (a_q[N-1] == b_q[N-1]) && (bus.add_s[WIDTH-1] != a_q[N-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed corner cases, backpressure, mid-run reset and a
// randomized regression against a full-width arithmetic reference.
module tb_multiword_add_seq;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = WIDTH * WORDS;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multiword_add_seq_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

  multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational adder slice
  always_comb begin
    {bus.add_c, bus.add_s} = (WIDTH+1)'(bus.add_a) + (WIDTH+1)'(bus.add_b)
                             + (WIDTH+1)'(bus.add_cin);
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] seen_a [WORDS];
  logic             seen_cin0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference result {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [N+1:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic cin, input logic sub);
    int          sa, sb, sr;
    logic [N:0]  ur;
    logic [N-1:0] s;
    logic        co, ov;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      sr = sa - sb;
    end else begin
      ur = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);
      s  = ur[N-1:0];
      co = ur[N];
      sr = sa + sb + int'(cin);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, s};
  endfunction

  task automatic junk_operands();
    bus.op_a   = N'($urandom);
    bus.op_b   = N'($urandom);
    bus.op_cin = 1'($urandom);
    bus.op_sub = 1'($urandom);
  endtask

  // One full transaction: issue, time the result, hold it under backpressure, release.
  // Called and returning on a falling edge.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                        input logic sub, input int hold, input bit poke);
    logic [N+1:0] exp;
    int lat;
    exp = ref_result(a, b, cin, sub);
    for (int k = 0; k < 20 && !bus.in_ready; k++) @(negedge clk);
    check_eq("in_ready", 32'(bus.in_ready), 32'd1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_cin   = cin;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.in_valid = poke ? 1'($urandom) : 1'b0;
      if (poke) junk_operands();
      if (lat <= WORDS) seen_a[lat-1] = bus.add_a;
      if (lat == 1) seen_cin0 = bus.add_cin;
    end while (!bus.out_valid && lat < 20);
    check_eq("latency", 32'(lat), 32'(WORDS + 1));
    check_eq("sum", 32'(bus.sum), 32'(exp[N-1:0]));
    check_eq("cout", 32'(bus.cout), 32'(exp[N]));
    check_eq("ovf", 32'(bus.ovf), 32'(exp[N+1]));
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      if (poke) begin
        bus.in_valid = 1'b1;
        junk_operands();
      end
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'(exp));
      if (poke) check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("drop_valid", 32'(bus.out_valid), 32'd0);
    check_eq("idle_ready", 32'(bus.in_ready), 32'd1);
    check_eq("idle_slice", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_cin    = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'd0);
    check_eq("rst_slice", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    check_eq("add_a_seq", 32'({seen_a[0], seen_a[1], seen_a[2], seen_a[3]}), 32'h0000_FF00);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    check_eq("cin_sum", 32'(bus.sum), 32'h0000_0001);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    check_eq("sub_first_cin", 32'(seen_cin0), 32'd1);
    check_eq("sub_sum", 32'(bus.sum), 32'h0000_FFFE);
    // Backpressure with competing operands offered during RUN and DONE
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 3, 1'b1);
    check_eq("bp_sum", 32'(bus.sum), 32'h0000_7FFF);

    // Abort mid-RUN with two slices already written
    bus.op_a     = 16'hAAAA;
    bus.op_b     = 16'h1111;
    bus.op_cin   = 1'b0;
    bus.op_sub   = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'd0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    check_eq("after_abort_sum", 32'(bus.sum), 32'h0000_5555);

    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
